mem_stage_lsu: RTL

- MEM-stage load/store unit of the 5-stage RISC-V pipeline.
- Producer end of the memory write-back path: issues data-memory requests over a valid/ready request channel plus a valid response channel.
- Returns aligned, sign/zero-extended load data as rd_data_MEM into the MEM/WB register; that value becomes rd_data_WB.
- Holds the pipeline with stall_MEM while an access is outstanding.

---
 rtl/mem_stage_lsu_pkg.sv | 21 ++
 rtl/mem_stage_lsu_load_align_ext.sv | 21 ++
 rtl/mem_stage_lsu.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared types and funct3 encodings for the MEM-stage load/store unit
package mem_stage_lsu_pkg;
  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;
  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT_RSP,
    LSU_DONE
  } lsu_state_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
endpackage

// File: rtl/mem_stage_lsu_load_align_ext.sv
// load_align_ext: shifts the addressed lane of a read word down and sign/zero-extends it
module load_align_ext
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            offset,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);
  logic [DATA_WIDTH-1:0] sh;
  // move the addressed byte/half to bit 0, then extend according to the load type
  always_comb begin
    sh = rdata >> {offset, 3'b000};
    data = funct3 == F3_LB  ? {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]} :
           funct3 == F3_LH  ? {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]} :
           funct3 == F3_LBU ? {{(DATA_WIDTH-8){1'b0}}, sh[7:0]} :
           funct3 == F3_LHU ? {{(DATA_WIDTH-16){1'b0}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit issuing data-memory requests and stalling the pipe
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_MEM,
  input  logic                  mem_write_MEM,
  input  logic [2:0]            funct3_MEM,
  input  logic [ADDR_WIDTH-1:0] alu_result_MEM,
  input  logic [DATA_WIDTH-1:0] rs2_data_MEM,
  output logic [DATA_WIDTH-1:0] rd_data_MEM,
  output logic                  stall_MEM,
  output logic                  mem_fault_MEM,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);
  lsu_state_e state, state_nx;
  logic access, misaligned, illegal, pend, hs;
  logic [1:0] off_q;
  logic [2:0] f3_q;
  logic [3:0] st_be;
  logic [DATA_WIDTH-1:0] st_wdata, fmt;
  // classify the access: a load wins when both read and write are set
  always_comb begin
    access = mem_read_MEM | mem_write_MEM;
    misaligned = funct3_MEM[1:0] == MEM_H ? alu_result_MEM[0] :
                 funct3_MEM[1:0] == MEM_W ? |alu_result_MEM[1:0] :
                 funct3_MEM[1:0] != MEM_B;
    illegal = mem_read_MEM ? funct3_MEM[2:1] == 2'b11 : funct3_MEM[2];
    mem_fault_MEM = access & (misaligned | illegal);
    pend = access & ~mem_fault_MEM;
    hs = state == LSU_IDLE & pend & dmem_req_ready;
  end
  // place store data on its byte lanes; sub-word data is replicated across the word
  always_comb begin
    st_be = funct3_MEM[1:0] == MEM_B ? 4'b0001 << alu_result_MEM[1:0] :
            funct3_MEM[1:0] == MEM_H ? (alu_result_MEM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    st_wdata = funct3_MEM[1:0] == MEM_B ? {4{rs2_data_MEM[7:0]}} :
               funct3_MEM[1:0] == MEM_H ? {2{rs2_data_MEM[15:0]}} : rs2_data_MEM;
  end
  // next state and handshake outputs; DONE releases the stall for exactly one cycle
  always_comb begin
    state_nx = state;
    dmem_req_valid = 1'b0;
    stall_MEM = 1'b0;
    case (state)
      LSU_IDLE: begin
        dmem_req_valid = pend;
        stall_MEM = pend;
        if (hs) state_nx = mem_read_MEM ? LSU_WAIT_RSP : LSU_DONE;
      end
      LSU_WAIT_RSP: begin
        stall_MEM = 1'b1;
        if (dmem_rsp_valid) state_nx = LSU_DONE;
      end
      default: state_nx = LSU_IDLE;
    endcase
  end
  assign dmem_we = dmem_req_valid & ~mem_read_MEM;
  assign dmem_be = dmem_req_valid ? (mem_read_MEM ? 4'b1111 : st_be) : 4'b0000;
  assign dmem_addr = {alu_result_MEM[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_wdata = st_wdata;
  load_align_ext #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .rdata(dmem_rdata),
    .offset(off_q),
    .funct3(f3_q),
    .data(fmt)
  );
  // state register; load format info captured at handshake, load data at response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LSU_IDLE;
      rd_data_MEM <= '0;
      off_q <= '0;
      f3_q <= '0;
    end else begin
      state <= state_nx;
      if (hs) begin
        off_q <= alu_result_MEM[1:0];
        f3_q <= funct3_MEM;
      end
      if (state == LSU_WAIT_RSP && dmem_rsp_valid) rd_data_MEM <= fmt;
    end
  end
endmodule
